pll_lock_supervisor: RTL

Supervises a board PLL such as the 720p pixel/TMDS generator. It synchronises the PLL's asynchronous LOCK output and drives the PLL's RST input. It releases a downstream reset only after lock has been continuously stable, retries the PLL on lock timeout, and latches a fault after repeated failures. It runs on the free-running 25 MHz board oscillator (the PLL's own reference), so it keeps working while the PLL outputs are absent.

---
 rtl/pll_lock_supervisor_pkg.sv | 12 +
 rtl/sync_bit.sv | 24 ++
 rtl/pll_lock_supervisor.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pll_lock_supervisor_pkg.sv
// Shared helpers for the PLL lock supervisor.
// Pure definitions, no logic of its own.
package pll_lock_supervisor_pkg;

   localparam int LOSS_W = 8;

   // Saturating increment for event counters that must never wrap back to zero.
   function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchroniser, resets to 0.
// Latency SYNC_STAGES clk edges; no backpressure.
module sync_bit #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      end
   end

   assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Resets the PLL, waits for stable lock, releases sys_rst; retries on timeout, faults after MAX_RETRY.
// Outputs registered, lock reaction SYNC_STAGES+1 edges; no backpressure.
module pll_lock_supervisor
   import pll_lock_supervisor_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int RST_PULSE      = 25,
   parameter int STABLE_CYCLES  = 250000,
   parameter int TIMEOUT_CYCLES = 2500000,
   parameter int MAX_RETRY      = 4
) (
   input  logic                           clk_25m,
   input  logic                           rst_n,
   input  logic                           pll_lock,
   output logic                           pll_rst,
   output logic                           sys_rst,
   output logic                           locked,
   output logic                           fault,
   output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
   output logic [7:0]                     lock_loss_cnt
);

   localparam int CNT_TOP = (RST_PULSE > STABLE_CYCLES) ? RST_PULSE : STABLE_CYCLES;
   localparam int CNT_W   = (CNT_TOP > 1) ? $clog2(CNT_TOP) : 1;
   localparam int TMO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int RETRY_W = $clog2(MAX_RETRY+1);

   localparam logic [CNT_W-1:0]   PULSE_LAST  = CNT_W'(RST_PULSE-1);
   localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES-1);
   localparam logic [TMO_W-1:0]   TMO_LAST    = TMO_W'(TIMEOUT_CYCLES-1);
   localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(MAX_RETRY-1);
   localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_RESET_PLL,
      S_WAIT_LOCK,
      S_STABLE,
      S_RUN,
      S_FAULT
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic [RETRY_W-1:0]  retry_q, retry_d;
   logic [LOSS_W-1:0]   loss_q, loss_d;
   logic                tmo_hit;
   logic                lock_s;

   sync_bit #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_lock_sync (
      .clk  (clk_25m),
      .rst_n(rst_n),
      .d    (pll_lock),
      .q    (lock_s)
   );

   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_RESET_PLL;
         cnt_q   <= '0;
         tmo_q   <= '0;
         retry_q <= '0;
         loss_q  <= '0;
         pll_rst <= 1'b1;
         sys_rst <= 1'b1;
         locked  <= 1'b0;
         fault   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         retry_q <= retry_d;
         loss_q  <= loss_d;
         pll_rst <= (state_d == S_RESET_PLL) || (state_d == S_FAULT);
         sys_rst <= (state_d != S_RUN);
         locked  <= (state_d == S_RUN);
         fault   <= (state_d == S_FAULT);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      retry_d = retry_q;
      loss_d  = loss_q;
      tmo_hit = 1'b0;
      case (state_q)
         S_RESET_PLL: begin
            if (cnt_q == PULSE_LAST) begin
               state_d = S_WAIT_LOCK;
               tmo_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT_LOCK: begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_q == TMO_LAST) begin
               tmo_hit = 1'b1;
            end else if (lock_s) begin
               state_d = S_STABLE;
               cnt_d   = '0;
            end
         end
         S_STABLE: begin
            tmo_d = tmo_q + 1'b1;
            // Completing the stable window beats a coincident timeout; a timeout beats a lock drop.
            if (lock_s && (cnt_q == STABLE_LAST)) begin
               state_d = S_RUN;
               retry_d = '0;
            end else if (tmo_q == TMO_LAST) begin
               tmo_hit = 1'b1;
            end else if (!lock_s) begin
               state_d = S_WAIT_LOCK;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RUN: begin
            if (!lock_s) begin
               state_d = S_RESET_PLL;
               cnt_d   = '0;
               loss_d  = sat_inc(loss_q);
            end
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_RESET_PLL;
            cnt_d   = '0;
         end
      endcase

      if (tmo_hit) begin
         cnt_d = '0;
         if (retry_q == RETRY_LAST) begin
            state_d = S_FAULT;
            retry_d = RETRY_MAX;
         end else begin
            state_d = S_RESET_PLL;
            retry_d = retry_q + 1'b1;
         end
      end
   end

   assign retry_cnt     = retry_q;
   assign lock_loss_cnt = loss_q;

endmodule
